// File: rtl/base_fifo_sync_if.sv
// base_fifo_sync_if: producer/consumer bundle for base_fifo_sync.
// o_high_water exists only when FIFO_SYNC_HIGHWATER_EN is defined.

interface base_fifo_sync_if #(
  parameter int Width          = 9,
  parameter int DataCountWidth = 5
);

  logic                      i_write;
  logic [Width-1:0]          i_din;
  logic                      i_read;
  logic [Width-1:0]          o_dout;
  logic                      o_valid;
  logic                      o_empty;
  logic                      o_full;
  logic                      o_prog_full;
  logic                      o_prog_empty;
  logic [DataCountWidth-1:0] o_data_count;
  logic                      o_wr_ack;
  logic                      o_overflow;
  logic                      o_underflow;
`ifdef FIFO_SYNC_HIGHWATER_EN
  logic [DataCountWidth-1:0] o_high_water;
`endif

`ifdef FIFO_SYNC_HIGHWATER_EN
  modport master (
    output i_write, i_din, i_read,
    input  o_dout, o_valid, o_empty, o_full,
    input  o_prog_full, o_prog_empty,
    input  o_data_count, o_wr_ack,
    input  o_overflow, o_underflow,
    input  o_high_water
  );

  modport slave (
    input  i_write, i_din, i_read,
    output o_dout, o_valid, o_empty, o_full,
    output o_prog_full, o_prog_empty,
    output o_data_count, o_wr_ack,
    output o_overflow, o_underflow,
    output o_high_water
  );
`else
  modport master (
    output i_write, i_din, i_read,
    input  o_dout, o_valid, o_empty, o_full,
    input  o_prog_full, o_prog_empty,
    input  o_data_count, o_wr_ack,
    input  o_overflow, o_underflow
  );

  modport slave (
    input  i_write, i_din, i_read,
    output o_dout, o_valid, o_empty, o_full,
    output o_prog_full, o_prog_empty,
    output o_data_count, o_wr_ack,
    output o_overflow, o_underflow
  );
`endif

endinterface

// File: rtl/base_fifo_sync.sv
// base_fifo_sync: single-clock FIFO, standard or FWFT read mode.
// FIFO_SYNC_HIGHWATER_EN adds o_high_water (peak occupancy since reset).

module base_fifo_sync #(
  parameter int Width          = 9,
  parameter int Depth          = 16,
  parameter int DataCountWidth = 5,
  parameter int ProgFullValue  = 12,
  parameter int ProgEmptyValue = 5,
  parameter int FirstWordFall  = 0
) (
  input logic             i_clk,
  input logic             i_reset,
  base_fifo_sync_if.slave bus
);

  localparam bit Fwft = (FirstWordFall != 0);
  localparam int AW   = $clog2(Depth);
  localparam int Cap  = Fwft ? Depth + 1 : Depth;

  localparam logic [DataCountWidth-1:0] CapC =
    DataCountWidth'(Cap);
  localparam logic [DataCountWidth-1:0] PfC =
    DataCountWidth'(ProgFullValue);
  localparam logic [DataCountWidth-1:0] PeC =
    DataCountWidth'(ProgEmptyValue);
  localparam logic [DataCountWidth-1:0] CntOne =
    DataCountWidth'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  logic [Width-1:0]          r_mem [Depth];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [DataCountWidth-1:0] r_count;
  logic [Width-1:0]          r_dout;
  logic                      r_valid;
  logic                      r_empty;
  logic                      r_full;
  logic                      r_prog_full;
  logic                      r_prog_empty;
  logic                      r_wr_ack;
  logic                      r_overflow;
  logic                      r_underflow;

  logic                      w_wr_ok;
  logic                      w_wr_en;
  logic                      w_rd_ok;
  logic                      w_fetch;
  logic                      w_valid_nxt;
  logic [DataCountWidth-1:0] w_ram_cnt;
  logic [DataCountWidth-1:0] w_count_nxt;
  logic [Width-1:0]          w_head;

  assign w_head = r_mem[r_rd_ptr];

  // Accept/reject decisions and next occupancy from pre-edge state.
  // In FWFT the output register is refilled from RAM whenever it is
  // empty or being popped; in standard mode RAM is read on each pop.
  always_comb begin
    w_wr_ok     = bus.i_write && !r_full;
    w_wr_en     = w_wr_ok && !i_reset;
    w_ram_cnt   = r_count;
    w_rd_ok     = bus.i_read && !r_empty;
    w_fetch     = w_rd_ok;
    w_valid_nxt = w_rd_ok;
    if (Fwft) begin
      w_ram_cnt   = r_count -
        {{(DataCountWidth-1){1'b0}}, r_valid};
      w_rd_ok     = bus.i_read && r_valid;
      w_fetch     = (!r_valid || w_rd_ok) &&
        (w_ram_cnt != '0);
      w_valid_nxt = w_fetch || (r_valid && !w_rd_ok);
    end
    unique case (1'b1)
      (w_wr_ok && !w_rd_ok): w_count_nxt = r_count + CntOne;
      (!w_wr_ok && w_rd_ok): w_count_nxt = r_count - CntOne;
      default:               w_count_nxt = r_count;
    endcase
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.i_din;
    end
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_fetch) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

  // Output word holds until the next RAM fetch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_dout <= w_head;
      end
      r_valid <= w_valid_nxt;
    end
  end

  // Occupancy and level flags, registered from next-state count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_prog_full  <= 1'b0;
      r_prog_empty <= 1'b1;
    end else begin
      r_count      <= w_count_nxt;
      r_empty      <= Fwft ? !w_valid_nxt
                           : (w_count_nxt == '0);
      r_full       <= (w_count_nxt == CapC);
      r_prog_full  <= (w_count_nxt >= PfC);
      r_prog_empty <= (w_count_nxt <= PeC);
    end
  end

  // One-cycle status pulses for the request seen last edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_ok;
      r_overflow  <= bus.i_write && r_full;
      r_underflow <= bus.i_read && !w_rd_ok;
    end
  end

`ifdef FIFO_SYNC_HIGHWATER_EN
  logic [DataCountWidth-1:0] r_high_water;

  // Peak occupancy; only reset lowers it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_high_water <= '0;
    end else if (w_count_nxt > r_high_water) begin
      r_high_water <= w_count_nxt;
    end
  end

  assign bus.o_high_water = r_high_water;
`endif

  assign bus.o_dout       = r_dout;
  assign bus.o_valid      = r_valid;
  assign bus.o_empty      = r_empty;
  assign bus.o_full       = r_full;
  assign bus.o_prog_full  = r_prog_full;
  assign bus.o_prog_empty = r_prog_empty;
  assign bus.o_data_count = r_count;
  assign bus.o_wr_ack     = r_wr_ack;
  assign bus.o_overflow   = r_overflow;
  assign bus.o_underflow  = r_underflow;

endmodule

// File: tb/tb_base_fifo_sync.sv
// tb_base_fifo_sync: standard and FWFT instances vs queue models.
// Honours FIFO_SYNC_HIGHWATER_EN when defined.

module tb_base_fifo_sync;

  typedef struct packed {
    logic [8:0] dout;
    logic       valid;
    logic       empty;
    logic       full;
    logic       pf;
    logic       pe;
    logic [4:0] cnt;
    logic       wa;
    logic       ov;
    logic       un;
    logic [4:0] hw;
  } obs_t;

  typedef struct {
    logic       rs;
    logic       w;
    logic       r;
    logic [8:0] din;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       wa;
    logic       ov;
    logic       un;
    logic       valid;
    logic [8:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  base_fifo_sync_if #(.Width(9), .DataCountWidth(5)) sif ();
  base_fifo_sync_if #(.Width(9), .DataCountWidth(5)) fif ();

  base_fifo_sync #(.FirstWordFall(0)) u_std (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (sif.slave)
  );

  base_fifo_sync #(.FirstWordFall(1)) u_fw (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (fif.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [8:0] qs[$];
  logic [8:0] qf[$];
  obs_t es, ef;
  int   hws, hwf;
  logic vf;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic obs_t get_s();
    obs_t o;
    o.dout  = sif.o_dout;
    o.valid = sif.o_valid;
    o.empty = sif.o_empty;
    o.full  = sif.o_full;
    o.pf    = sif.o_prog_full;
    o.pe    = sif.o_prog_empty;
    o.cnt   = sif.o_data_count;
    o.wa    = sif.o_wr_ack;
    o.ov    = sif.o_overflow;
    o.un    = sif.o_underflow;
`ifdef FIFO_SYNC_HIGHWATER_EN
    o.hw    = sif.o_high_water;
`else
    o.hw    = '0;
`endif
    return o;
  endfunction

  function automatic obs_t get_f();
    obs_t o;
    o.dout  = fif.o_dout;
    o.valid = fif.o_valid;
    o.empty = fif.o_empty;
    o.full  = fif.o_full;
    o.pf    = fif.o_prog_full;
    o.pe    = fif.o_prog_empty;
    o.cnt   = fif.o_data_count;
    o.wa    = fif.o_wr_ack;
    o.ov    = fif.o_overflow;
    o.un    = fif.o_underflow;
`ifdef FIFO_SYNC_HIGHWATER_EN
    o.hw    = fif.o_high_water;
`else
    o.hw    = '0;
`endif
    return o;
  endfunction

  // Standard mode: 16 words, popped word appears on Dout.
  task automatic model_std(input logic rs, w, r,
                           input logic [8:0] d);
    int pre, n;
    logic wok, rok;
    if (rs) begin
      qs.delete();
      es = '0;
      es.empty = 1'b1;
      es.pe = 1'b1;
      hws = 0;
      return;
    end
    pre = qs.size();
    wok = w && (pre < 16);
    rok = r && (pre > 0);
    es.wa = wok;
    es.ov = w && !wok;
    es.un = r && !rok;
    es.valid = rok;
    if (rok) es.dout = qs.pop_front();
    if (wok) qs.push_back(d);
    n = qs.size();
    es.cnt = 5'(n);
    es.empty = (n == 0);
    es.full = (n == 16);
    es.pf = (n >= 12);
    es.pe = (n <= 5);
    if (n > hws) hws = n;
`ifdef FIFO_SYNC_HIGHWATER_EN
    es.hw = 5'(hws);
`else
    es.hw = '0;
`endif
  endtask

  // FWFT: 17 words; a word is visible once it was stored
  // before the edge and everything ahead of it is gone.
  task automatic model_fw(input logic rs, w, r,
                          input logic [8:0] d);
    int pre, n;
    logic wok, rok;
    if (rs) begin
      qf.delete();
      ef = '0;
      ef.empty = 1'b1;
      ef.pe = 1'b1;
      hwf = 0;
      vf = 1'b0;
      return;
    end
    pre = qf.size();
    wok = w && (pre < 17);
    rok = r && vf;
    ef.wa = wok;
    ef.ov = w && !wok;
    ef.un = r && !rok;
    if (rok) void'(qf.pop_front());
    vf = (qf.size() > 0);
    if (vf) ef.dout = qf[0];
    if (wok) qf.push_back(d);
    n = qf.size();
    ef.valid = vf;
    ef.empty = !vf;
    ef.cnt = 5'(n);
    ef.full = (n == 17);
    ef.pf = (n >= 12);
    ef.pe = (n <= 5);
    if (n > hwf) hwf = n;
`ifdef FIFO_SYNC_HIGHWATER_EN
    ef.hw = 5'(hwf);
`else
    ef.hw = '0;
`endif
  endtask

  task automatic step(input logic rs, w, r,
                      input logic [8:0] d);
    rst = rs;
    sif.i_write = w;
    sif.i_read = r;
    sif.i_din = d;
    fif.i_write = w;
    fif.i_read = r;
    fif.i_din = d;
    @(posedge clk);
    #1;
    model_std(rs, w, r, d);
    model_fw(rs, w, r, d);
    check("std_model", 64'(get_s()), 64'(es));
    check("fwft_model", 64'(get_f()), 64'(ef));
  endtask

  vec_t tbl[10];

  initial begin
    logic [8:0] rd;
    obs_t o;

    tbl[0] = '{1, 0, 0, 9'h000, 0, 1, 0, 0, 0, 0, 0, 9'h000};
    tbl[1] = '{0, 0, 0, 9'h000, 0, 1, 0, 0, 0, 0, 0, 9'h000};
    tbl[2] = '{0, 1, 0, 9'h055, 1, 0, 0, 1, 0, 0, 0, 9'h000};
    tbl[3] = '{0, 1, 0, 9'h0AA, 2, 0, 0, 1, 0, 0, 0, 9'h000};
    tbl[4] = '{0, 0, 1, 9'h000, 1, 0, 0, 0, 0, 0, 1, 9'h055};
    tbl[5] = '{0, 1, 1, 9'h033, 1, 0, 0, 1, 0, 0, 1, 9'h0AA};
    tbl[6] = '{0, 0, 1, 9'h000, 0, 1, 0, 0, 0, 0, 1, 9'h033};
    tbl[7] = '{0, 0, 1, 9'h000, 0, 1, 0, 0, 0, 1, 0, 9'h033};
    tbl[8] = '{0, 1, 1, 9'h011, 1, 0, 0, 1, 0, 1, 0, 9'h033};
    tbl[9] = '{0, 0, 0, 9'h000, 1, 0, 0, 0, 0, 0, 0, 9'h033};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rs, tbl[i].w, tbl[i].r, tbl[i].din);
      o = get_s();
      check($sformatf("tbl%0d", i),
        64'({o.cnt, o.empty, o.full, o.wa, o.ov,
             o.un, o.valid, o.dout}),
        64'({tbl[i].cnt, tbl[i].empty, tbl[i].full,
             tbl[i].wa, tbl[i].ov, tbl[i].un,
             tbl[i].valid, tbl[i].dout}));
    end

    // Fill 1..16, then one more.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 9'(i));
      if (i == 11) check("pf_at_11", 64'(sif.o_prog_full), 0);
      if (i == 12) check("pf_at_12", 64'(sif.o_prog_full), 1);
    end
    check("std_full", 64'({sif.o_full, sif.o_data_count}),
          64'({1'b1, 5'd16}));
    check("fw_notfull16", 64'(fif.o_full), 0);
    step(0, 1, 0, 9'h111);
    check("std_ovf",
      64'({sif.o_overflow, sif.o_wr_ack, sif.o_data_count}),
      64'({1'b1, 1'b0, 5'd16}));
    check("fw_full17", 64'({fif.o_full, fif.o_data_count}),
          64'({1'b1, 5'd17}));

    // Drain in order, then one extra read.
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0);
      check($sformatf("drain%0d", i),
            64'({sif.o_valid, sif.o_dout}),
            64'({1'b1, 9'(i)}));
    end
    check("std_empty", 64'(sif.o_empty), 1);
    step(0, 0, 1, 0);
    check("std_unf", 64'({sif.o_underflow, sif.o_valid}),
          64'({1'b1, 1'b0}));

    // FWFT write-to-Dout latency of two edges.
    step(1, 0, 0, 0);
    step(0, 1, 0, 9'h0AB);
    check("fw_lat1", 64'({fif.o_valid, fif.o_empty}),
          64'({1'b0, 1'b1}));
    step(0, 0, 0, 0);
    check("fw_lat2",
      64'({fif.o_valid, fif.o_empty, fif.o_dout}),
      64'({1'b1, 1'b0, 9'h0AB}));

    // Steady read+write at count 8 across pointer wrap.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 9'(9'h100 + i));
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 9'($urandom));
      check("rw_cnt8",
        64'({sif.o_data_count, fif.o_data_count}),
        64'({5'd8, 5'd8}));
    end
    for (int i = 0; i < 8; i++) step(0, 1, 0, 9'($urandom));
    step(0, 1, 1, 9'h1EE);
    check("rw_full",
      64'({sif.o_overflow, sif.o_valid, sif.o_data_count}),
      64'({1'b1, 1'b1, 5'd15}));

    // Reset mid-stream with a concurrent write.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 9'(i));
    step(1, 1, 0, 9'h1FF);
    check("rst_mid",
      64'({sif.o_data_count, sif.o_empty,
           fif.o_data_count, fif.o_empty}),
      64'({5'd0, 1'b1, 5'd0, 1'b1}));
`ifdef FIFO_SYNC_HIGHWATER_EN
    check("rst_hw", 64'(sif.o_high_water), 0);
`endif

    // Random traffic with shifting bias and rare resets.
    for (int i = 0; i < 900; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (100 - wp),
           9'($urandom));
    end

    rd = 9'h0;
    step(0, 0, 0, rd);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/base_fifo_sync.md
# base_fifo_sync

Single-clock, parametrised FIFO for the common test and peripheral paths. It is the synchronous successor to the async distributed-RAM FIFO wrappers. Width, depth, thresholds and read mode (standard or first-word-fall-through) are set at instantiation. It adds write acknowledge, overflow/underflow reporting and a full-range occupancy count. It sits between a producer and a consumer in the same clock domain, where no CDC synchroniser is needed.

## Interface
Parameters:
- Width, 9, data word width in bits (1..64)
- Depth, 16, RAM entries; power of two, 4..1024
- DataCountWidth, 5, width of DataCount; must be ≥ clog2(Depth)+1
- ProgFullValue, 12, ProgFull threshold (1..capacity-1)
- ProgEmptyValue, 5, ProgEmpty threshold (0..capacity-2)
- FirstWordFall, 0, 0 = standard read mode, 1 = first-word-fall-through (FWFT)

Ports:
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Write  in  1  write request
- Din  in  Width  write data
- Read  in  1  read request (standard) / pop of head word (FWFT)
- Dout  out  Width  read data
- Valid  out  1  Dout holds a valid word
- Empty  out  1  no word available to read
- Full  out  1  write will be rejected
- ProgFull  out  1  DataCount ≥ ProgFullValue
- ProgEmpty  out  1  DataCount ≤ ProgEmptyValue
- DataCount  out  DataCountWidth  occupancy, 0..capacity
- WrAck  out  1  previous-cycle write was accepted
- Overflow  out  1  previous-cycle write was rejected (Full)
- Underflow  out  1  previous-cycle read was rejected (Empty)

## Operation
- Capacity = Depth (standard) or Depth+1 (FWFT; the output register holds one word).
- Storage is an inferred RAM with write pointer and read pointer, each clog2(Depth) bits, wrapping modulo Depth. An occupancy counter is kept separately; full/empty is never derived from pointer equality.
- A write is accepted iff Write && !Full. The read rules per mode are below. Flags are evaluated on pre-edge state.
- Standard mode: a read is accepted iff Read && !Empty. Dout is loaded from RAM at that edge. Valid pulses high for one cycle. Dout holds its value until the next accepted read. Empty = (count == 0).
- FWFT mode:
  - Prefetch loads the RAM head into Dout whenever the output register is empty, or is being popped this cycle, and the RAM holds data.
  - Valid = output register occupied; Empty = !Valid.
  - A read is accepted iff Read && Valid.
- DataCount is the total stored words (RAM + output register in FWFT). Per edge it changes by +1, -1 or 0. It saturates by construction and never exceeds capacity.
- Simultaneous read and write:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected (Overflow).
  - Empty: write accepted, read rejected (Underflow).
- Rejected operations never modify pointers, count or Dout.

## Timing
- All outputs are registered and update on the same edge that performs the operation.
- Reset values (after any edge with Reset=1): Dout=0, Valid=0, Empty=1, Full=0, ProgFull=0, ProgEmpty=1, DataCount=0, WrAck=0, Overflow=0, Underflow=0, pointers=0.
- Write/Read asserted during a Reset cycle are ignored. Reset mid-operation discards all contents.
- Standard mode:
  - Write at edge N: Empty=0 and DataCount+1 visible after N.
  - Read at edge N+1: Dout/Valid visible after N+1, a read latency of 1.
- FWFT mode: a write into an empty FIFO at edge N is prefetched at N+1. Valid=1, Empty=0 and Dout=word are visible after N+1. Write-to-Dout latency is 2.
- Full asserts after the edge that brings the count to capacity. It deasserts after the first accepted read.
- WrAck, Overflow and Underflow are single-cycle pulses one edge after the request.

## Configuration
- FIFO_SYNC_HIGHWATER_EN defined:
  - Adds output HighWater [DataCountWidth] holding the maximum DataCount reached since reset.
  - Updates on the same edge as DataCount. Reset value is 0, and only Reset clears it.
- Not defined: the port and its register are absent, and behaviour is otherwise identical.

## Test plan
Directed scenarios at the default parameters (Depth=16, Width=9) unless stated:
- Reset, then idle: Empty=1, ProgEmpty=1, DataCount=0, Valid=0, all pulses 0.
- Standard: write 0x001..0x010, 16 words -> Full=1 after the 16th edge, ProgFull=1 from count 12, DataCount=16. A 17th write gives Overflow=1, WrAck=0, count stays 16.
- Standard: read 16 words -> Dout sequence 0x001..0x010 with Valid one cycle after each Read. Empty=1 after the last. An extra Read gives Underflow=1.
- FWFT (FirstWordFall=1): a single write of 0x0AB into an empty FIFO -> Valid=1, Dout=0x0AB two edges after the write. Capacity is 17, so Full=1 at DataCount=17.
- Simultaneous Read+Write every cycle for 40 cycles at count 8 -> count stays 8 across pointer wrap, data order preserved. At count 16 (full) the write is rejected and the read is accepted. At count 0 the write is accepted and the read gives Underflow.
- Reset asserted mid-stream with count 10 plus concurrent Write -> after the edge DataCount=0, Empty=1, the write is dropped. With FIFO_SYNC_HIGHWATER_EN, HighWater=0 after the reset edge.
